// File: rtl/or_gate_bist_if.sv
// Bus between the BIST sequencer and the OR logic unit it exercises.
//   dut_a, dut_b : operands driven by the sequencer (master)
//   dut_c        : OR result returned by the logic unit (slave)
//   dut_zero     : zero flag returned by the logic unit (slave)
interface or_gate_bist_if #(
   parameter int unsigned WIDTH = 20
);
   logic [WIDTH-1:0] dut_a;
   logic [WIDTH-1:0] dut_b;
   logic [WIDTH-1:0] dut_c;
   logic             dut_zero;

   modport master (
      output dut_a,
      output dut_b,
      input  dut_c,
      input  dut_zero
   );

   modport slave (
      input  dut_a,
      input  dut_b,
      output dut_c,
      output dut_zero
   );
endinterface

// File: rtl/or_gate_bist.sv
// Built-in self-test sequencer for the OR logic unit. Each iteration drives a pair of
// LFSR operands (DRIVE), then checks the unit's c/zero against a|b (CHECK).
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a run (sampled only when idle)
//   busy       : run in progress
//   done       : one-cycle pulse at the end of a run
//   pass       : last run had no mismatches, held until the next start
//   err_count  : mismatching iterations, saturating
//   fail_index : first failing iteration, all-ones if none
//   lu         : operand/result bus to the logic unit (master side)
module or_gate_bist #(
   parameter int unsigned      WIDTH     = 20,
   parameter int unsigned      NUM_ITERS = 10,
   parameter logic [WIDTH-1:0] SEED      = 20'h0C128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [15:0]         err_count,
   output logic [15:0]         fail_index,
   or_gate_bist_if.master      lu
);

   typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

   // Only reachable when NUM_ITERS > 0, so the wrap for zero is harmless.
   localparam logic [15:0] LastIter = 16'(NUM_ITERS - 1);

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [15:0]      err_q, err_d;
   logic [15:0]      fail_q, fail_d;
   logic [15:0]      iter_q, iter_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] expected;
   logic             mismatch;

   // Fibonacci LFSR, x^20 + x^17 + 1.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] l);
      return {l[WIDTH-2:0], l[WIDTH-1] ^ l[WIDTH-4]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fail_q  <= '1;
         iter_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         lfsr_q  <= SEED;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         iter_q  <= iter_d;
         a_q     <= a_d;
         b_q     <= b_d;
         lfsr_q  <= lfsr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      err_d    = err_q;
      fail_d   = fail_q;
      iter_d   = iter_q;
      a_d      = a_q;
      b_d      = b_q;
      lfsr_d   = lfsr_q;
      expected = '0;
      mismatch = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               lfsr_d = SEED;
               err_d  = '0;
               fail_d = '1;
               iter_d = '0;
               pass_d = 1'b0;
               if (NUM_ITERS == 0) begin
                  done_d = 1'b1;
                  pass_d = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  state_d = StDrive;
               end
            end
         end
         StDrive: begin
            a_d     = lfsr_q;
            b_d     = lfsr_step(lfsr_q);
            lfsr_d  = lfsr_step(lfsr_step(lfsr_q));
            state_d = StCheck;
         end
         StCheck: begin
            expected = a_q | b_q;
            mismatch = (lu.dut_c != expected) || (lu.dut_zero != (expected == '0));
            if (mismatch) begin
               if (err_q != 16'hFFFF) begin
                  err_d = err_q + 16'd1;
               end
               if (fail_q == 16'hFFFF) begin
                  fail_d = iter_q;
               end
            end
            iter_d = iter_q + 16'd1;
            if (iter_q == LastIter) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_q == 16'd0) && !mismatch;
               state_d = StIdle;
            end else begin
               state_d = StDrive;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_index = fail_q;
   assign lu.dut_a   = a_q;
   assign lu.dut_b   = b_q;

endmodule

// File: tb/tb_or_gate_bist.sv
// Bench for or_gate_bist: a timeline model predicts every output each cycle, with a
// configurable fake OR unit so mismatches can be injected; a second instance covers
// the zero-iteration build.
module tb_or_gate_bist;
   localparam int          W    = 20;
   localparam int          N    = 10;
   localparam logic [19:0] SEED = 20'h0C128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic start0 = 1'b0;
   always #5 clk = ~clk;

   logic        busy, done, pass;
   logic [15:0] err_count, fail_index;
   logic        busy0, done0, pass0;
   logic [15:0] err_count0, fail_index0;

   or_gate_bist_if #(.WIDTH(W)) bus ();
   or_gate_bist_if #(.WIDTH(W)) bus0 ();

   or_gate_bist #(.WIDTH(W), .NUM_ITERS(N), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_index(fail_index), .lu(bus)
   );

   or_gate_bist #(.WIDTH(W), .NUM_ITERS(0), .SEED(SEED)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err_count0), .fail_index(fail_index0), .lu(bus0)
   );

   // Fake OR unit with fault knobs.
   logic        f_c0 = 1'b0;
   logic        f_z1 = 1'b0;
   logic [19:0] f_cmask = '0;
   logic        f_zflip = 1'b0;
   assign bus.dut_c    = f_c0 ? 20'h0 : ((bus.dut_a | bus.dut_b) ^ f_cmask);
   assign bus.dut_zero = (f_c0 | f_z1) ? 1'b1 : (((bus.dut_a | bus.dut_b) == 20'h0) ^ f_zflip);
   assign bus0.dut_c    = bus0.dut_a | bus0.dut_b;
   assign bus0.dut_zero = (bus0.dut_a | bus0.dut_b) == 20'h0;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Operand sequence: successive LFSR states from the seed.
   logic [19:0] seq [0:2*N-1];

   // Timeline model.
   bit          chk_en = 1'b0;
   bit          m_active = 1'b0;
   int          m_phase = 0;
   logic        m_done = 1'b0;
   logic        m_pass = 1'b0;
   logic [15:0] m_err = '0;
   logic [15:0] m_fail = 16'hFFFF;
   logic [19:0] m_a = '0;
   logic [19:0] m_b = '0;

   initial begin
      forever begin
         logic [19:0] e, uc;
         logic        uz;
         int          i;
         @(posedge clk);
         m_done = 1'b0;
         if (rst) begin
            m_active = 1'b0;
            m_pass   = 1'b0;
            m_err    = '0;
            m_fail   = 16'hFFFF;
            m_a      = '0;
            m_b      = '0;
            chk_en   = 1'b1;
         end else if (m_active) begin
            m_phase++;
            if (m_phase % 2 == 1) begin
               i   = (m_phase - 1) / 2;
               m_a = seq[2*i];
               m_b = seq[2*i+1];
            end else begin
               e  = m_a | m_b;
               uc = f_c0 ? 20'h0 : (e ^ f_cmask);
               uz = (f_c0 | f_z1) ? 1'b1 : ((e == 20'h0) ^ f_zflip);
               if (uc != e || uz != (e == 20'h0)) begin
                  if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                  if (m_fail == 16'hFFFF) m_fail = 16'(m_phase / 2 - 1);
               end
               if (m_phase == 2 * N) begin
                  m_active = 1'b0;
                  m_done   = 1'b1;
                  m_pass   = (m_err == 16'd0);
               end
            end
         end else if (start) begin
            m_err    = '0;
            m_fail   = 16'hFFFF;
            m_pass   = 1'b0;
            m_phase  = 0;
            m_active = 1'b1;
         end
      end
   end

   // Per-cycle compare against the model.
   int done_cnt = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("err_count", 32'(err_count), 32'(m_err));
            chk("fail_index", 32'(fail_index), 32'(m_fail));
            chk("dut_a", 32'(bus.dut_a), 32'(m_a));
            chk("dut_b", 32'(bus.dut_b), 32'(m_b));
            if (done === 1'b1) done_cnt++;
         end
      end
   end

   int busy0_hi = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (busy0 === 1'b1) busy0_hi++;
      end
   end

   logic [19:0] first_a, first_b;
   int          lat;

   task automatic run_and_wait();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            first_a = bus.dut_a;
            first_b = bus.dut_b;
         end
      end
      if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int d0;
      seq[0] = SEED;
      for (int k = 1; k < 2 * N; k++) seq[k] = {seq[k-1][18:0], seq[k-1][19] ^ seq[k-1][16]};
      chk("seq_a0", 32'(seq[0]), 32'h0C128);
      chk("seq_b0", 32'(seq[1]), 32'h18250);
      chk("seq_or0", 32'(seq[0] | seq[1]), 32'h1C378);

      // Reset values.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_fail", 32'(fail_index), 32'hFFFF);
      chk("rst_a", 32'(bus.dut_a), 32'd0);
      chk("rst_b", 32'(bus.dut_b), 32'd0);
      chk("rst0_fail", 32'(fail_index0), 32'hFFFF);
      rst = 1'b0;
      @(negedge clk);

      // Correct unit.
      run_and_wait();
      chk("good_first_a", 32'(first_a), 32'h0C128);
      chk("good_first_b", 32'(first_b), 32'h18250);
      chk("good_latency", 32'(lat), 32'd20);
      chk("good_pass", 32'(pass), 32'd1);
      chk("good_err", 32'(err_count), 32'd0);
      chk("good_fail", 32'(fail_index), 32'hFFFF);
      repeat (3) @(negedge clk);

      // c stuck at 0, zero stuck at 1.
      f_c0 = 1'b1;
      run_and_wait();
      chk("c0_err", 32'(err_count), 32'd10);
      chk("c0_fail", 32'(fail_index), 32'd0);
      chk("c0_pass", 32'(pass), 32'd0);
      f_c0 = 1'b0;
      repeat (2) @(negedge clk);

      // Only the zero flag is wrong.
      f_z1 = 1'b1;
      run_and_wait();
      chk("z1_err", 32'(err_count), 32'd10);
      chk("z1_pass", 32'(pass), 32'd0);
      f_z1 = 1'b0;
      repeat (2) @(negedge clk);

      // start held during a run: one done only.
      d0 = done_cnt;
      start = 1'b1;
      repeat (15) @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("held_start_done_count", 32'(done_cnt - d0), 32'd1);

      // Reset mid-run: back to reset values, no done.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_err", 32'(err_count), 32'd0);
      chk("abort_fail", 32'(fail_index), 32'hFFFF);
      chk("abort_a", 32'(bus.dut_a), 32'd0);
      d0 = done_cnt;
      repeat (25) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_and_wait();
      chk("restart_first_a", 32'(first_a), 32'h0C128);
      repeat (2) @(negedge clk);

      // Zero-iteration build.
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("n0_done", 32'(done0), 32'd1);
      chk("n0_pass", 32'(pass0), 32'd1);
      chk("n0_err", 32'(err_count0), 32'd0);
      @(negedge clk);
      chk("n0_done_pulse", 32'(done0), 32'd0);
      chk("n0_pass_held", 32'(pass0), 32'd1);

      // Randomized runs: random faults, stray starts, one mid-run reset.
      for (int r = 0; r < 8; r++) begin
         bit faulty;
         faulty = ($urandom_range(1) == 1);
         repeat ($urandom_range(3)) @(negedge clk);
         start = 1'b1;
         for (int c = 0; c < 2 * N + 4; c++) begin
            @(negedge clk);
            start = ($urandom_range(3) == 0);
            if (faulty) begin
               f_cmask = ($urandom_range(3) == 0) ? (20'h1 << $urandom_range(19)) : 20'h0;
               f_zflip = ($urandom_range(5) == 0);
            end
            rst = (r == 5 && c == 7);
         end
         start = 1'b0;
         rst = 1'b0;
         f_cmask = '0;
         f_zflip = 1'b0;
         repeat (2 * N + 3) @(negedge clk);
      end

      chk("n0_busy_never", 32'(busy0_hi), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
